game_event_sequencer: RTL and testbench

//  Downstream consumer of the four ghost FSMs, pacman controller and pellet map. Merges ghost-eaten and

---
 rtl/game_event_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_game_event_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_event_sequencer.sv
// Game-flow sequencer: merges ghost/pacman events, owns score, combo and lives, and drives actor
// freeze plus respawn/reload/restart pulses. Optional bonus life under `EXTRA_LIFE_EN`.
module game_event_sequencer #(
    parameter int unsigned START_LIVES      = 3,
    parameter int unsigned EAT_PAUSE_FRAMES = 60,
    parameter int unsigned DEATH_FRAMES     = 90,
    parameter int unsigned CLEAR_FRAMES     = 120,
    parameter int unsigned PELLET_TOTAL     = 244
`ifdef EXTRA_LIFE_EN
    ,
    parameter int unsigned EXTRA_LIFE_SCORE = 10000
`endif
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [3:0]  ghost_eaten,
    input  logic [3:0]  ghost_kill,
    input  logic        pellet_pulse,
    input  logic        power_pulse,
    input  logic [19:0] points_eaten,
    input  logic        start_key,
    output logic [19:0] score,
    output logic [2:0]  lives,
    output logic        freeze,
    output logic        soft_reset,
    output logic        new_map,
    output logic        hard_reset,
    output logic        game_over,
    output logic [6:0]  anim_frame
);

    localparam logic [2:0]  LIVES_INIT = 3'(START_LIVES);
    localparam logic [19:0] PELLETS    = 20'(PELLET_TOTAL);
    localparam logic [6:0]  EAT_LAST   = 7'(EAT_PAUSE_FRAMES - 1);
    localparam logic [6:0]  DEATH_LAST = 7'(DEATH_FRAMES - 1);
    localparam logic [6:0]  CLEAR_LAST = 7'(CLEAR_FRAMES - 1);

    typedef enum logic [2:0] {
        StPlay,
        StEatPause,
        StDying,
        StClear,
        StGameOver
    } state_e;

    state_e      state_q, state_d;
    logic [19:0] score_q, score_d;
    logic [2:0]  lives_q, lives_d;
    logic [1:0]  combo_q, combo_d;
    logic [3:0]  pend_q, pend_d;
    logic [3:0]  eaten_q;
    logic [6:0]  anim_q, anim_d;
    logic        soft_q, soft_d;
    logic        newmap_q, newmap_d;
    logic        hard_q, hard_d;

    logic [3:0]  eat_rise, pend_all, serve_sel;
    logic        serve;
    logic [20:0] add, sum;

    assign eat_rise  = ghost_eaten & ~eaten_q;
    assign pend_all  = pend_q | eat_rise;
    // Isolate the lowest set bit so ghost0 is served before higher-numbered ghosts.
    assign serve_sel = pend_all & (~pend_all + 4'd1);

`ifdef EXTRA_LIFE_EN
    localparam logic [19:0] EXTRA_THR = 20'(EXTRA_LIFE_SCORE);
    logic bonus_q, bonus_d;
`endif

    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        combo_d  = combo_q;
        pend_d   = pend_all;
        anim_d   = anim_q + 7'd1;
        soft_d   = 1'b0;
        newmap_d = 1'b0;
        hard_d   = 1'b0;
        serve    = 1'b0;
        add      = 21'd0;

        unique case (state_q)
            StPlay: begin
                if (|ghost_kill) begin
                    state_d = StDying;
                    pend_d  = 4'd0;
                end else begin
                    if (pellet_pulse) add = add + 21'd10;
                    if (power_pulse)  add = add + 21'd50;
                    if (pend_all != 4'd0) begin
                        serve   = 1'b1;
                        state_d = StEatPause;
                    end else if (points_eaten == PELLETS) begin
                        state_d = StClear;
                    end
                end
            end
            StEatPause: begin
                if (anim_q == EAT_LAST) begin
                    if (pend_all != 4'd0) serve = 1'b1;
                    else                  state_d = StPlay;
                end
            end
            StDying: begin
                if (anim_q == DEATH_LAST) begin
                    lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                    if (lives_q <= 3'd1) begin
                        state_d = StGameOver;
                    end else begin
                        state_d = StPlay;
                        soft_d  = 1'b1;
                        combo_d = 2'd0;
                    end
                end
            end
            StClear: begin
                if (anim_q == CLEAR_LAST) begin
                    state_d  = StPlay;
                    newmap_d = 1'b1;
                    combo_d  = 2'd0;
                end
            end
            StGameOver: begin
                if (start_key) begin
                    state_d = StPlay;
                    hard_d  = 1'b1;
                    lives_d = LIVES_INIT;
                    combo_d = 2'd0;
                    pend_d  = 4'd0;
                end
            end
            default: state_d = StPlay;
        endcase

        if (serve) begin
            add     = add + {1'b0, 20'd200 << combo_q};
            pend_d  = pend_all & ~serve_sel;
            combo_d = (combo_q == 2'd3) ? 2'd3 : combo_q + 2'd1;
        end
        // A served eat has already used the old combo; power resets the chain behind it.
        if (power_pulse) combo_d = serve ? 2'd1 : 2'd0;

        sum     = {1'b0, score_q} + add;
        score_d = sum[20] ? 20'hFFFFF : sum[19:0];
        if (hard_d) score_d = 20'd0;

        if (serve || state_d != state_q || state_d == StPlay || state_d == StGameOver) begin
            anim_d = 7'd0;
        end

`ifdef EXTRA_LIFE_EN
        bonus_d = bonus_q;
        if (hard_d) begin
            bonus_d = 1'b0;
        end else if (!bonus_q && score_q < EXTRA_THR && score_d >= EXTRA_THR) begin
            bonus_d = 1'b1;
            lives_d = (lives_d == 3'd7) ? 3'd7 : lives_d + 3'd1;
        end
`endif
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q  <= StPlay;
            score_q  <= 20'd0;
            lives_q  <= LIVES_INIT;
            combo_q  <= 2'd0;
            pend_q   <= 4'd0;
            eaten_q  <= 4'd0;
            anim_q   <= 7'd0;
            soft_q   <= 1'b0;
            newmap_q <= 1'b0;
            hard_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            combo_q  <= combo_d;
            pend_q   <= pend_d;
            eaten_q  <= ghost_eaten;
            anim_q   <= anim_d;
            soft_q   <= soft_d;
            newmap_q <= newmap_d;
            hard_q   <= hard_d;
        end
    end

`ifdef EXTRA_LIFE_EN
    always_ff @(posedge frame_clk) begin
        if (Reset) bonus_q <= 1'b0;
        else       bonus_q <= bonus_d;
    end
`endif

    assign score      = score_q;
    assign lives      = lives_q;
    assign freeze     = (state_q != StPlay);
    assign game_over  = (state_q == StGameOver);
    assign soft_reset = soft_q;
    assign new_map    = newmap_q;
    assign hard_reset = hard_q;
    assign anim_frame = anim_q;

endmodule

// File: tb/tb_game_event_sequencer.sv
// Directed bench for game_event_sequencer: per-frame vector table plus hand sequences for
// eat pauses, death, game over/restart, maze clear, bonus life and score saturation.
module tb_game_event_sequencer;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [3:0]  ghost_eaten, ghost_kill;
    logic        pellet_pulse, power_pulse, start_key;
    logic [19:0] points_eaten;
    logic [19:0] score;
    logic [2:0]  lives;
    logic        freeze, soft_reset, new_map, hard_reset, game_over;
    logic [6:0]  anim_frame;

    int n_tests = 0;
    int n_fail  = 0;

    game_event_sequencer dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .ghost_eaten  (ghost_eaten),
        .ghost_kill   (ghost_kill),
        .pellet_pulse (pellet_pulse),
        .power_pulse  (power_pulse),
        .points_eaten (points_eaten),
        .start_key    (start_key),
        .score        (score),
        .lives        (lives),
        .freeze       (freeze),
        .soft_reset   (soft_reset),
        .new_map      (new_map),
        .hard_reset   (hard_reset),
        .game_over    (game_over),
        .anim_frame   (anim_frame)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [3:0]  ge;
        logic        pel;
        logic        pow;
        logic [19:0] pts;
        logic [19:0] exp_score;
        logic        exp_freeze;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ghost_eaten  = 4'd0;
        ghost_kill   = 4'd0;
        pellet_pulse = 1'b0;
        power_pulse  = 1'b0;
        points_eaten = 20'd0;
        start_key    = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
    endtask

    // Eat one ghost in PLAY and ride out the full 60-frame pause.
    task automatic eat_one(input logic [3:0] g, input logic pow, input logic [19:0] exp_score,
                           input string name);
        ghost_eaten = g;
        power_pulse = pow;
        tick(1);
        ghost_eaten = 4'd0;
        power_pulse = 1'b0;
        check({name, "_score"}, 32'(score), 32'(exp_score));
        check({name, "_freeze0"}, 32'(freeze), 1);
        tick(59);
        check({name, "_freeze59"}, 32'(freeze), 1);
        check({name, "_anim59"}, 32'(anim_frame), 59);
        tick(1);
        check({name, "_unfreeze"}, 32'(freeze), 0);
    endtask

    task automatic die(input logic [2:0] exp_lives, input logic exp_soft, input logic exp_go,
                       input string name);
        ghost_kill = 4'b0100;
        tick(1);
        ghost_kill = 4'd0;
        check({name, "_freeze"}, 32'(freeze), 1);
        tick(89);
        check({name, "_anim89"}, 32'(anim_frame), 89);
        check({name, "_still_frozen"}, 32'(freeze), 1);
        tick(1);
        check({name, "_lives"}, 32'(lives), 32'(exp_lives));
        check({name, "_soft"}, 32'(soft_reset), 32'(exp_soft));
        check({name, "_game_over"}, 32'(game_over), 32'(exp_go));
    endtask

    initial begin
        vecs[0] = '{ge: 4'd0, pel: 1'b1, pow: 1'b0, pts: 20'd0,   exp_score: 20'd10,  exp_freeze: 1'b0};
        vecs[1] = '{ge: 4'd0, pel: 1'b0, pow: 1'b1, pts: 20'd0,   exp_score: 20'd60,  exp_freeze: 1'b0};
        vecs[2] = '{ge: 4'd0, pel: 1'b1, pow: 1'b1, pts: 20'd0,   exp_score: 20'd120, exp_freeze: 1'b0};
        vecs[3] = '{ge: 4'd0, pel: 1'b0, pow: 1'b0, pts: 20'd243, exp_score: 20'd120, exp_freeze: 1'b0};
        vecs[4] = '{ge: 4'd0, pel: 1'b1, pow: 1'b0, pts: 20'd100, exp_score: 20'd130, exp_freeze: 1'b0};
        vecs[5] = '{ge: 4'd0, pel: 1'b0, pow: 1'b0, pts: 20'd0,   exp_score: 20'd130, exp_freeze: 1'b0};

        idle_inputs();
        do_reset();
        tick(10);
        check("rst_score", 32'(score), 0);
        check("rst_lives", 32'(lives), 3);
        check("rst_freeze", 32'(freeze), 0);
        check("rst_pulses", 32'({soft_reset, new_map, hard_reset}), 0);
        check("rst_game_over", 32'(game_over), 0);
        check("rst_anim", 32'(anim_frame), 0);

        for (int i = 0; i < 6; i++) begin
            ghost_eaten  = vecs[i].ge;
            pellet_pulse = vecs[i].pel;
            power_pulse  = vecs[i].pow;
            points_eaten = vecs[i].pts;
            tick(1);
            check($sformatf("vec%0d_score", i), 32'(score), 32'(vecs[i].exp_score));
            check($sformatf("vec%0d_freeze", i), 32'(freeze), 32'(vecs[i].exp_freeze));
        end
        idle_inputs();

        // Combo chain 200/400/800/1600, then saturated at 1600.
        eat_one(4'b0001, 1'b0, 20'd330,  "eat_g0");
        eat_one(4'b0010, 1'b0, 20'd730,  "eat_g1");
        eat_one(4'b0100, 1'b0, 20'd1530, "eat_g2");
        eat_one(4'b1000, 1'b0, 20'd3130, "eat_g3");
        eat_one(4'b0010, 1'b0, 20'd4730, "eat_sat");

        // Two ghosts in one frame: ghost0 first, ghost2 served at end of first pause.
        power_pulse = 1'b1;
        tick(1);
        power_pulse = 1'b0;
        check("power_score", 32'(score), 4780);
        ghost_eaten = 4'b0101;
        tick(1);
        ghost_eaten = 4'd0;
        check("dual_first", 32'(score), 4980);
        tick(60);
        check("dual_second", 32'(score), 5380);
        check("dual_anim_restart", 32'(anim_frame), 0);
        check("dual_frozen", 32'(freeze), 1);
        tick(60);
        check("dual_unfreeze", 32'(freeze), 0);

        // Power with eat: old combo (800) used, combo becomes 1 so next eat is 400.
        eat_one(4'b0001, 1'b1, 20'd6230, "pow_eat");
        eat_one(4'b0010, 1'b0, 20'd6630, "after_pow");

        // Kill and eat in the same frame: kill wins, no points.
        ghost_eaten = 4'b0010;
        die(3'd2, 1'b1, 1'b0, "die1");
        check("kill_wins_score", 32'(score), 6630);
        ghost_eaten = 4'd0;
        tick(1);
        check("soft_one_frame", 32'(soft_reset), 0);
        check("no_late_eat", 32'(freeze), 0);
        die(3'd1, 1'b1, 1'b0, "die2");
        tick(1);
        die(3'd0, 1'b0, 1'b1, "die3");
        tick(5);
        check("go_hold", 32'(game_over), 1);
        check("go_lives", 32'(lives), 0);
        check("go_freeze", 32'(freeze), 1);
        start_key = 1'b1;
        tick(1);
        start_key = 1'b0;
        check("hard_pulse", 32'(hard_reset), 1);
        check("hard_lives", 32'(lives), 3);
        check("hard_score", 32'(score), 0);
        check("hard_go_clear", 32'(game_over), 0);
        tick(1);
        check("hard_one_frame", 32'(hard_reset), 0);

        // Reset during DYING.
        pellet_pulse = 1'b1;
        tick(1);
        pellet_pulse = 1'b0;
        ghost_kill = 4'b0001;
        tick(1);
        ghost_kill = 4'd0;
        tick(10);
        check("mid_dying_frozen", 32'(freeze), 1);
        Reset = 1'b1;
        tick(1);
        check("mid_rst_freeze", 32'(freeze), 0);
        check("mid_rst_anim", 32'(anim_frame), 0);
        check("mid_rst_score", 32'(score), 0);
        check("mid_rst_pulses", 32'({soft_reset, new_map, hard_reset}), 0);
        Reset = 1'b0;
        tick(1);

        // Maze clear; pellets during CLEAR do not score.
        points_eaten = 20'd244;
        tick(1);
        points_eaten = 20'd0;
        check("clear_freeze", 32'(freeze), 1);
        pellet_pulse = 1'b1;
        tick(1);
        pellet_pulse = 1'b0;
        check("clear_no_score", 32'(score), 0);
        tick(118);
        check("clear_anim119", 32'(anim_frame), 119);
        check("clear_no_map_yet", 32'(new_map), 0);
        tick(1);
        check("new_map_pulse", 32'(new_map), 1);
        check("clear_unfreeze", 32'(freeze), 0);
        tick(1);
        check("new_map_one_frame", 32'(new_map), 0);

        // Bonus-life threshold at 10000.
        do_reset();
        power_pulse = 1'b1;
        tick(199);
        power_pulse = 1'b0;
        pellet_pulse = 1'b1;
        tick(4);
        pellet_pulse = 1'b0;
        check("pre_bonus_score", 32'(score), 9990);
        check("pre_bonus_lives", 32'(lives), 3);
        pellet_pulse = 1'b1;
        tick(1);
        check("bonus_score", 32'(score), 10000);
`ifdef EXTRA_LIFE_EN
        check("bonus_lives", 32'(lives), 4);
`else
        check("bonus_lives", 32'(lives), 3);
`endif
        tick(1);
        pellet_pulse = 1'b0;
        check("bonus_once_score", 32'(score), 10010);
`ifdef EXTRA_LIFE_EN
        check("bonus_once_lives", 32'(lives), 4);
`else
        check("bonus_once_lives", 32'(lives), 3);
`endif

        // Score saturation at 20'hFFFFF.
        do_reset();
        power_pulse = 1'b1;
        tick(20971);
        check("near_sat", 32'(score), 1048550);
        tick(1);
        power_pulse = 1'b0;
        check("sat_score", 32'(score), 32'h000FFFFF);
        pellet_pulse = 1'b1;
        tick(1);
        pellet_pulse = 1'b0;
        check("sat_hold", 32'(score), 32'h000FFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
